dmem_responder: RTL and testbench

Target end of the CPU data-memory interface: a byte-addressable, little-endian RV32 data memory that executes loads and stores issued by a load/store initiator.
Uses a valid/ready request channel and a valid/ready response channel, with a programmable wait-state count.
Supports LB/LH/LW/LBU/LHU/SB/SH/SW selected by funct3, and reports misaligned or illegal accesses.
Replaces the single-cycle data memory when the core moves to a multi-cycle memory stage.

---
 rtl/dmem_if.sv | 26 ++
 rtl/dmem_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_responder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Load/store request and response channels between the data-memory initiator
// and responder: valid/ready request (we, funct3, addr, wdata) and response (rdata, err).
interface dmem_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Byte-addressable little-endian RV32 data memory with programmable wait states.
// Ports: clk, rst (async active-high), bus (dmem_if slave: request and response channels).
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);
    localparam int WORDS = 1 << (ADDR_W - 2);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state, state_n;
    logic [7:0]        cnt;
    logic              l_we;
    logic [2:0]        l_f3;
    logic [ADDR_W-1:0] l_addr;
    logic [31:0]       l_wdata;

    logic [31:0]       mem [WORDS];
    logic [31:0]       mem_word;
    logic [1:0]        lane;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       acc_rdata;
    logic              acc_err;
    logic              wr_en;
    logic [3:0]        be;
    logic [31:0]       wd;
    logic              fire;

    assign bus.req_ready = (state == IDLE);
    assign mem_word      = mem[l_addr[ADDR_W-1:2]];
    assign fire          = (state == WAIT) && (cnt == 8'd0);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (bus.req_valid)      state_n = WAIT;
            WAIT: if (cnt == 8'd0)        state_n = RESP;
            RESP: if (bus.rsp_ready)      state_n = IDLE;
            default:                      state_n = IDLE;
        endcase
    end

    // Access decode works on the latched request; it is only consumed on the
    // final WAIT edge, so it is harmless while idle.
    always_comb begin
        acc_rdata = '0;
        acc_err   = 1'b0;
        be        = '0;
        wd        = '0;
        lane      = l_addr[1:0];
        byte_v    = mem_word[8*lane +: 8];
        half_v    = l_addr[1] ? mem_word[31:16] : mem_word[15:0];
        if (l_we) begin
            case (l_f3)
                3'b000: begin
                    be = 4'b0001 << lane;
                    wd = {4{l_wdata[7:0]}};
                end
                3'b001: begin
                    if (l_addr[0]) acc_err = 1'b1;
                    else be = l_addr[1] ? 4'b1100 : 4'b0011;
                    wd = {2{l_wdata[15:0]}};
                end
                3'b010: begin
                    if (lane != 2'd0) acc_err = 1'b1;
                    else be = 4'b1111;
                    wd = l_wdata;
                end
                default: acc_err = 1'b1;
            endcase
        end else begin
            case (l_f3)
                3'b000: acc_rdata = {{24{byte_v[7]}}, byte_v};
                3'b100: acc_rdata = {24'd0, byte_v};
                3'b001: begin
                    if (l_addr[0]) acc_err = 1'b1;
                    else acc_rdata = {{16{half_v[15]}}, half_v};
                end
                3'b101: begin
                    if (l_addr[0]) acc_err = 1'b1;
                    else acc_rdata = {16'd0, half_v};
                end
                3'b010: begin
                    if (lane != 2'd0) acc_err = 1'b1;
                    else acc_rdata = mem_word;
                end
                default: acc_err = 1'b1;
            endcase
        end
        wr_en = fire && l_we && !acc_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            l_we          <= 1'b0;
            l_f3          <= '0;
            l_addr        <= '0;
            l_wdata       <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        l_we    <= bus.req_we;
                        l_f3    <= bus.req_funct3;
                        l_addr  <= bus.req_addr;
                        l_wdata <= bus.req_wdata;
                        cnt     <= 8'(WAIT_CYCLES);
                    end
                end
                WAIT: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= acc_rdata;
                        bus.rsp_err   <= acc_err;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Array is deliberately not reset; a reset in WAIT leaves the state at
    // IDLE so the pending store never reaches this write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[l_addr[ADDR_W-1:2]][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table of loads/stores plus
// backpressure and mid-transaction reset sequences.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;

    dmem_if #(.ADDR_W(8)) bus ();

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    vec_t tv[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issue a request, wait for the response, complete it with rsp_ready.
    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [7:0] a,
                          input logic [31:0] wdat, input logic hold,
                          output logic [31:0] rd, output logic er, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wdat;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        if (!hold) begin
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.rsp_ready = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.rsp_ready  = 1'b0;

        tv.push_back('{1'b1, 3'b010, 8'h10, 32'hDEADBEEF, 32'h0,        1'b0});
        tv.push_back('{1'b0, 3'b010, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0});
        tv.push_back('{1'b0, 3'b000, 8'h13, 32'h0,        32'hFFFFFFDE, 1'b0});
        tv.push_back('{1'b0, 3'b100, 8'h13, 32'h0,        32'h000000DE, 1'b0});
        tv.push_back('{1'b0, 3'b001, 8'h12, 32'h0,        32'hFFFFDEAD, 1'b0});
        tv.push_back('{1'b0, 3'b101, 8'h10, 32'h0,        32'h0000BEEF, 1'b0});
        tv.push_back('{1'b1, 3'b000, 8'h11, 32'h00000055, 32'h0,        1'b0});
        tv.push_back('{1'b0, 3'b010, 8'h10, 32'h0,        32'hDEAD55EF, 1'b0});
        tv.push_back('{1'b1, 3'b001, 8'h12, 32'h00001234, 32'h0,        1'b0});
        tv.push_back('{1'b0, 3'b010, 8'h10, 32'h0,        32'h123455EF, 1'b0});
        tv.push_back('{1'b0, 3'b001, 8'h11, 32'h0,        32'h0,        1'b1});
        tv.push_back('{1'b1, 3'b010, 8'h12, 32'hFFFFFFFF, 32'h0,        1'b1});
        tv.push_back('{1'b0, 3'b010, 8'h10, 32'h0,        32'h123455EF, 1'b0});
        tv.push_back('{1'b0, 3'b011, 8'h10, 32'h0,        32'h0,        1'b1});
        tv.push_back('{1'b1, 3'b011, 8'h10, 32'hFFFFFFFF, 32'h0,        1'b1});
        tv.push_back('{1'b1, 3'b001, 8'h13, 32'hFFFFFFFF, 32'h0,        1'b1});
        tv.push_back('{1'b0, 3'b010, 8'h10, 32'h0,        32'h123455EF, 1'b0});
        tv.push_back('{1'b0, 3'b000, 8'h10, 32'h0,        32'hFFFFFFEF, 1'b0});
        tv.push_back('{1'b0, 3'b000, 8'h11, 32'h0,        32'h00000055, 1'b0});
        tv.push_back('{1'b0, 3'b001, 8'h10, 32'h0,        32'h000055EF, 1'b0});
        tv.push_back('{1'b0, 3'b101, 8'h12, 32'h0,        32'h00001234, 1'b0});
        tv.push_back('{1'b0, 3'b010, 8'h11, 32'h0,        32'h0,        1'b1});
        tv.push_back('{1'b0, 3'b110, 8'h10, 32'h0,        32'h0,        1'b1});
        tv.push_back('{1'b1, 3'b010, 8'hFC, 32'hCAFEF00D, 32'h0,        1'b0});
        tv.push_back('{1'b0, 3'b010, 8'hFC, 32'h0,        32'hCAFEF00D, 1'b0});
        tv.push_back('{1'b1, 3'b010, 8'h20, 32'h11223344, 32'h0,        1'b0});

        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rsp_err",   32'(bus.rsp_err), 32'h0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            do_txn(tv[i].we, tv[i].f3, tv[i].addr, tv[i].wd, 1'b0, rd, er, lat);
            chk($sformatf("v%0d_rdata", i), rd, tv[i].rd);
            chk($sformatf("v%0d_err", i), 32'(er), 32'(tv[i].err));
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
        end

        // Backpressure: response held while rsp_ready is low.
        do_txn(1'b0, 3'b010, 8'h10, 32'h0, 1'b1, rd, er, lat);
        chk("bp_first_rdata", rd, 32'h123455EF);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 8'h10;
        bus.req_wdata  = 32'h0BADF00D;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid", k), 32'(bus.rsp_valid), 32'h1);
            chk($sformatf("bp%0d_rdata", k), bus.rsp_rdata, 32'h123455EF);
            chk($sformatf("bp%0d_req_ready", k), 32'(bus.req_ready), 32'h0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        chk("bp_release_valid", 32'(bus.rsp_valid), 32'h0);
        chk("bp_release_req_ready", 32'(bus.req_ready), 32'h1);
        repeat (5) @(negedge clk);
        chk("bp_no_accept_valid", 32'(bus.rsp_valid), 32'h0);
        do_txn(1'b0, 3'b010, 8'h10, 32'h0, 1'b0, rd, er, lat);
        chk("bp_store_ignored", rd, 32'h123455EF);

        // Reset during WAIT of a store discards it.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 8'h20;
        bus.req_wdata  = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("wait_req_ready", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.rsp_valid), 32'h0);
        chk("mid_rst_rdata", bus.rsp_rdata, 32'h0);
        chk("mid_rst_err",   32'(bus.rsp_err), 32'h0);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        do_txn(1'b0, 3'b010, 8'h20, 32'h0, 1'b0, rd, er, lat);
        chk("post_rst_rdata", rd, 32'h11223344);
        chk("post_rst_err", 32'(er), 32'h0);

        // Reset while a response is pending drops it.
        do_txn(1'b0, 3'b010, 8'h20, 32'h0, 1'b1, rd, er, lat);
        chk("resp_pending_valid", 32'(bus.rsp_valid), 32'h1);
        rst = 1'b1;
        #1;
        chk("resp_drop_valid", 32'(bus.rsp_valid), 32'h0);
        chk("resp_drop_rdata", bus.rsp_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        do_txn(1'b0, 3'b000, 8'h23, 32'h0, 1'b0, rd, er, lat);
        chk("post_drop_lb", rd, 32'h00000011);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
